// File: rtl/serial_magnitude_comparator_if.sv
// Operand/cascade request and verdict response bundle for serial_magnitude_comparator.
// The master drives the request side; the comparator is the slave.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             G_in;
    logic             E_in;
    logic             L_in;
    logic             busy;
    logic             done;
    logic             G_o;
    logic             E_o;
    logic             L_o;

    modport master (
        output start, A, B, G_in, E_in, L_in,
        input  busy, done, G_o, E_o, L_o
    );

    modport slave (
        input  start, A, B, G_in, E_in, L_in,
        output busy, done, G_o, E_o, L_o
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial LSB-first cascadable magnitude comparator; WIDTH+1 cycles from start to done.
// Define SERIAL_CMP_SIGNED_EN for a two's-complement compare; start while busy is dropped.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  cmp
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef SERIAL_CMP_SIGNED_EN
    localparam bit SIGNED_CMP = 1'b1;
`else
    localparam bit SIGNED_CMP = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Running verdict: gt/lt flags, neither set means equal.
    logic               vg_q, vg_d;
    logic               vl_q, vl_d;
    logic               rg_q, rg_d;
    logic               rl_q, rl_d;

    logic               last_bit;
    logic               bit_gt;
    logic               bit_lt;
    logic               unused_e_in;

    // E_in never decides anything: G_in and L_in win, and all-zero already means equal.
    assign unused_e_in = cmp.E_in;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            vg_q    <= 1'b0;
            vl_q    <= 1'b0;
            rg_q    <= 1'b0;
            rl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            vg_q    <= vg_d;
            vl_q    <= vl_d;
            rg_q    <= rg_d;
            rl_q    <= rl_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmp.start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Datapath: operands shift right so bit 0 is always the bit under test
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        vg_d   = vg_q;
        vl_d   = vl_q;
        rg_d   = rg_q;
        rl_d   = rl_q;
        bit_gt = a_q[0] & ~b_q[0];
        bit_lt = ~a_q[0] & b_q[0];
        // In two's complement a set sign bit means the smaller value.
        if (SIGNED_CMP && last_bit) begin
            bit_gt = ~a_q[0] & b_q[0];
            bit_lt = a_q[0] & ~b_q[0];
        end
        case (state_q)
            ST_IDLE: begin
                if (cmp.start) begin
                    a_d   = cmp.A;
                    b_d   = cmp.B;
                    cnt_d = '0;
                    vg_d  = cmp.G_in;
                    vl_d  = ~cmp.G_in & cmp.L_in;
                end
            end
            ST_SHIFT: begin
                if (bit_gt) begin
                    vg_d = 1'b1;
                    vl_d = 1'b0;
                end else if (bit_lt) begin
                    vg_d = 1'b0;
                    vl_d = 1'b1;
                end
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                // Result is loaded on entry to DONE so it is valid alongside done.
                if (last_bit) begin
                    rg_d = vg_d;
                    rl_d = vl_d;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        cmp.busy = (state_q != ST_IDLE);
        cmp.done = (state_q == ST_DONE);
        cmp.G_o  = rg_q;
        cmp.L_o  = rl_q;
        cmp.E_o  = ~rg_q & ~rl_q;
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboarded random and directed bench for serial_magnitude_comparator (WIDTH=8).
module tb_serial_magnitude_comparator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_magnitude_comparator_if #(.WIDTH(W)) cif ();

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .cmp (cif)
    );

    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference verdict as {G,E,L}: compare whole words, fall back on the cascade.
    function automatic logic [2:0] ref_gel(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic gi, input logic li);
        int sa, sb;
`ifdef SERIAL_CMP_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        if (sa > sb)      return 3'b100;
        else if (sa < sb) return 3'b001;
        else if (gi)      return 3'b100;
        else if (li)      return 3'b001;
        else              return 3'b010;
    endfunction

    // Monitor: every done pops one expected verdict
    always @(negedge clk) begin
        if (!rst && cif.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_GEL", int'({cif.G_o, cif.E_o, cif.L_o}), int'(mon_exp));
            end
        end
    end

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic gi, input logic ei, input logic li,
                           input bit late_starts, input int abort_at);
        int first_done;
        int dones;
        int busy_cnt;
        cif.A     = a;
        cif.B     = b;
        cif.G_in  = gi;
        cif.E_in  = ei;
        cif.L_in  = li;
        cif.start = 1'b1;
        exp_q.push_back(ref_gel(a, b, gi, li));
        first_done = -1;
        dones      = 0;
        busy_cnt   = 0;
        for (int n = 1; n <= W + 4; n++) begin
            @(negedge clk);
            cif.start = 1'b0;
            cif.A     = W'($urandom);
            cif.B     = W'($urandom);
            cif.G_in  = 1'($urandom);
            cif.E_in  = 1'($urandom);
            cif.L_in  = 1'($urandom);
            if (late_starts && (n == 2 || n == 5)) begin
                cif.start = 1'b1;
                cif.A     = 8'hFF;
                cif.B     = 8'h00;
            end
            if (cif.busy) busy_cnt++;
            if (cif.done) begin
                dones++;
                if (first_done < 0) first_done = n;
            end
            if (n == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                void'(exp_q.pop_back());
                check("abort_busy", int'(cif.busy), 0);
                check("abort_done", int'(cif.done), 0);
                check("abort_GEL", int'({cif.G_o, cif.E_o, cif.L_o}), 3'b010);
                check("abort_no_done_before", dones, 0);
                return;
            end
        end
        check("done_count", dones, 1);
        check("done_latency", first_done, W + 1);
        check("busy_cycles", busy_cnt, W + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cif.start = 1'b0;
        cif.A     = '0;
        cif.B     = '0;
        cif.G_in  = 1'b0;
        cif.E_in  = 1'b0;
        cif.L_in  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(cif.busy), 0);
        check("reset_done", int'(cif.done), 0);
        check("reset_GEL", int'({cif.G_o, cif.E_o, cif.L_o}), 3'b010);
        rst = 1'b0;
        @(negedge clk);

        run_cmp(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_cmp(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_cmp(8'h33, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        run_cmp(8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        run_cmp(8'h33, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        run_cmp(8'h33, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_cmp(8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        run_cmp(8'hC3, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        run_cmp(8'h7F, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            run_cmp(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom_range(0, 3) == 0), -1);
        end
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            run_cmp(v, v, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
